// File: rtl/bus_arbiter6.sv
// Round-robin arbiter sharing one downstream bus port among six requesters.
// The grant is held from acceptance until the final response beat.
module bus_arbiter6 #(
    parameter bit PRIO0_FIXED = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_req,
    output logic       o_m_valid,
    input  logic       i_m_ready,
    input  logic       i_r_valid,
    input  logic       i_r_last,
    output logic [2:0] o_sel,
    output logic [5:0] o_gnt,
    output logic [5:0] o_done,
    output logic       o_busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e     r_state, w_state_next;
    logic [2:0] r_sel, w_sel_next;
    logic [5:0] r_gnt, w_gnt_next;
    logic [5:0] r_done, w_done_next;
    logic [2:0] r_ptr, w_ptr_next;

    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_cand;

    // Winner search starts just after the previous winner; in fixed mode bit 0
    // pre-empts and the rotation covers 1..5 only.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = 3'd0;
        if (PRIO0_FIXED && i_req[0]) begin
            w_found = 1'b1;
        end else begin
            for (int i = 1; i <= 6; i++) begin
                if (PRIO0_FIXED) begin
                    w_cand = 3'(((int'(r_ptr) + 4 + i) % 5) + 1);
                end else begin
                    w_cand = 3'((int'(r_ptr) + i) % 6);
                end
                if (!w_found && i_req[w_cand]) begin
                    w_found = 1'b1;
                    w_win   = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_gnt_next   = r_gnt;
        w_done_next  = 6'd0;
        w_ptr_next   = r_ptr;
        unique case (r_state)
            StIdle: begin
                // The cycle carrying done never arbitrates, so done precedes any new grant.
                if ((r_done == 6'd0) && w_found) begin
                    w_state_next = StAddr;
                    w_sel_next   = w_win;
                    w_gnt_next   = 6'b000001 << w_win;
                end
            end
            StAddr: begin
                if (i_m_ready) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                if (i_r_valid && i_r_last) begin
                    w_state_next = StIdle;
                    w_gnt_next   = 6'd0;
                    w_done_next  = r_gnt;
                    w_ptr_next   = r_sel;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_gnt_next   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_sel   <= 3'd0;
            r_gnt   <= 6'd0;
            r_done  <= 6'd0;
            r_ptr   <= 3'd5;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_ptr   <= w_ptr_next;
        end
    end

    assign o_m_valid = (r_state == StAddr);
    assign o_busy    = (r_state != StIdle);
    assign o_sel     = r_sel;
    assign o_gnt     = r_gnt;
    assign o_done    = r_done;

endmodule

// File: tb/tb_bus_arbiter6.sv
// Directed self-checking bench for bus_arbiter6: default rotation instance
// plus a fixed-priority instance driven in lockstep from the same inputs.
module tb_bus_arbiter6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] req;
    logic       m_ready, r_valid, r_last;

    logic       mv0, busy0, mv1, busy1;
    logic [2:0] sel0, sel1;
    logic [5:0] gnt0, done0, gnt1, done1;

    logic       use_p;
    logic       cur_mv, cur_busy;
    logic [2:0] cur_sel;
    logic [5:0] cur_gnt, cur_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_arbiter6 #(.PRIO0_FIXED(1'b0)) u_dut_rr (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .o_m_valid (mv0),
        .i_m_ready (m_ready),
        .i_r_valid (r_valid),
        .i_r_last  (r_last),
        .o_sel     (sel0),
        .o_gnt     (gnt0),
        .o_done    (done0),
        .o_busy    (busy0)
    );

    bus_arbiter6 #(.PRIO0_FIXED(1'b1)) u_dut_p0 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .o_m_valid (mv1),
        .i_m_ready (m_ready),
        .i_r_valid (r_valid),
        .i_r_last  (r_last),
        .o_sel     (sel1),
        .o_gnt     (gnt1),
        .o_done    (done1),
        .o_busy    (busy1)
    );

    assign cur_mv   = use_p ? mv1   : mv0;
    assign cur_busy = use_p ? busy1 : busy0;
    assign cur_sel  = use_p ? sel1  : sel0;
    assign cur_gnt  = use_p ? gnt1  : gnt0;
    assign cur_done = use_p ? done1 : done0;

    function automatic logic [5:0] oh(input logic [2:0] w);
        return 6'b000001 << w;
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 6'd0;
        m_ready = 1'b0;
        r_valid = 1'b0;
        r_last  = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered just after the grant edge; leaves the bench in the done cycle.
    task automatic run_txn(input logic [2:0] w, input int wait_n, input string tag);
        check_eq({tag, ".gnt"}, 8'(cur_gnt), 8'(oh(w)));
        check_eq({tag, ".sel"}, 8'(cur_sel), 8'(w));
        check_eq({tag, ".mv"}, 8'(cur_mv), 8'd1);
        check_eq({tag, ".busy"}, 8'(cur_busy), 8'd1);
        repeat (wait_n) begin
            tick();
            check_eq({tag, ".mv_hold"}, 8'(cur_mv), 8'd1);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq({tag, ".mv_drop"}, 8'(cur_mv), 8'd0);
        check_eq({tag, ".gnt_data"}, 8'(cur_gnt), 8'(oh(w)));
        r_valid = 1'b1;
        r_last  = 1'b1;
        tick();
        r_valid = 1'b0;
        r_last  = 1'b0;
        check_eq({tag, ".done"}, 8'(cur_done), 8'(oh(w)));
        check_eq({tag, ".gnt_off"}, 8'(cur_gnt), 8'd0);
        check_eq({tag, ".busy_off"}, 8'(cur_busy), 8'd0);
        check_eq({tag, ".sel_keep"}, 8'(cur_sel), 8'(w));
    endtask

    task automatic gap_check(input string tag);
        tick();
        check_eq({tag, ".gap_gnt"}, 8'(cur_gnt), 8'd0);
        check_eq({tag, ".gap_done"}, 8'(cur_done), 8'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        use_p = 1'b0;

        // Reset values, single requester with a stalled address phase
        do_reset();
        check_eq("rst.gnt", 8'(gnt0), 8'd0);
        check_eq("rst.sel", 8'(sel0), 8'd0);
        check_eq("rst.mv", 8'(mv0), 8'd0);
        check_eq("rst.busy", 8'(busy0), 8'd0);
        check_eq("rst.done", 8'(done0), 8'd0);
        req = 6'b000001;
        tick();
        run_txn(3'd0, 2, "t1");
        req = 6'd0;
        m_ready = 1'b1;
        r_valid = 1'b1;
        r_last  = 1'b1;
        tick();
        tick();
        check_eq("t1.idle_busy", 8'(busy0), 8'd0);
        check_eq("t1.idle_mv", 8'(mv0), 8'd0);
        check_eq("t1.idle_done", 8'(done0), 8'd0);
        m_ready = 1'b0;
        r_valid = 1'b0;
        r_last  = 1'b0;

        // All requesting: full rotation with one idle cycle between transactions
        do_reset();
        req = 6'h3f;
        tick();
        run_txn(3'd0, 0, "t2_0");
        for (int k = 1; k <= 6; k++) begin
            gap_check($sformatf("t2_%0d", k));
            run_txn(3'(k % 6), 0, $sformatf("t2_%0d", k));
        end
        req = 6'd0;

        // Wrap-around from last=4
        do_reset();
        req = 6'b010000;
        tick();
        run_txn(3'd4, 0, "t3a");
        req = 6'b000011;
        gap_check("t3b");
        run_txn(3'd0, 0, "t3b");
        gap_check("t3c");
        run_txn(3'd1, 0, "t3c");
        req = 6'd0;

        // Fixed priority for requester 0, rotation over 1..5
        do_reset();
        use_p = 1'b1;
        req = 6'b100001;
        tick();
        run_txn(3'd0, 0, "t4a0");
        for (int k = 1; k <= 2; k++) begin
            gap_check($sformatf("t4a%0d", k));
            run_txn(3'd0, 0, $sformatf("t4a%0d", k));
        end
        req = 6'b100010;
        gap_check("t4b0");
        run_txn(3'd1, 0, "t4b0");
        gap_check("t4b1");
        run_txn(3'd5, 0, "t4b1");
        gap_check("t4b2");
        run_txn(3'd1, 0, "t4b2");
        req = 6'd0;
        use_p = 1'b0;

        // Mid-DATA disturbances do not move the grant
        do_reset();
        req = 6'b000001;
        tick();
        check_eq("t5.gnt", 8'(gnt0), 8'b000001);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("t5.mv_drop", 8'(mv0), 8'd0);
        req     = 6'b001001;
        m_ready = 1'b1;
        r_valid = 1'b1;
        r_last  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq($sformatf("t5.hold_gnt%0d", k), 8'(gnt0), 8'b000001);
            check_eq($sformatf("t5.hold_sel%0d", k), 8'(sel0), 8'd0);
            check_eq($sformatf("t5.hold_busy%0d", k), 8'(busy0), 8'd1);
            check_eq($sformatf("t5.hold_mv%0d", k), 8'(mv0), 8'd0);
        end
        m_ready = 1'b0;
        r_last  = 1'b1;
        tick();
        r_valid = 1'b0;
        r_last  = 1'b0;
        check_eq("t5.done", 8'(done0), 8'b000001);
        check_eq("t5.gnt_off", 8'(gnt0), 8'd0);
        req = 6'b001000;
        gap_check("t5b");
        run_txn(3'd3, 0, "t5b");
        req = 6'd0;

        // Asynchronous reset in the middle of a DATA phase
        do_reset();
        req = 6'b000100;
        tick();
        check_eq("t6.gnt", 8'(gnt0), 8'b000100);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("t6.busy", 8'(busy0), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6.rst_gnt", 8'(gnt0), 8'd0);
        check_eq("t6.rst_mv", 8'(mv0), 8'd0);
        check_eq("t6.rst_sel", 8'(sel0), 8'd0);
        check_eq("t6.rst_busy", 8'(busy0), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 6'h3f;
        tick();
        check_eq("t6.win_gnt", 8'(gnt0), 8'b000001);
        check_eq("t6.win_sel", 8'(sel0), 8'd0);
        check_eq("t6.win_mv", 8'(mv0), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
